icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache with one-word lines. Sits between the CPU fetch stage and the instruction port of the sram-like-to-AXI bridge.
- Accepts sram-like fetch requests and serves hits from local arrays. On a miss, or for an uncached address, it issues one single-word sram-like read downstream.
- Cacheable misses are refilled into the arrays. One request is outstanding at a time.

Parameters:
- INDEX_W, 8, index bits; the cache has 2**INDEX_W lines of 32 bits.
- UNCACHED_SEG, 3'b101, value of addr[31:29] that marks an uncached access (kseg1).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- cpu_inst_req  in  1  fetch request, held until cpu_inst_addr_ok
- cpu_inst_size  in  2  access size (0=byte, 1=half, 2=word)
- cpu_inst_addr  in  32  fetch address
- cpu_inst_addr_ok  out  1  request accepted this cycle
- cpu_inst_data_ok  out  1  one-cycle pulse: cpu_inst_rdata valid
- cpu_inst_rdata  out  32  fetched word
- cache_inv  in  1  pulse: invalidate all lines
- mem_inst_req  out  1  downstream request
- mem_inst_wr  out  1  constant 0
- mem_inst_size  out  2  downstream size
- mem_inst_addr  out  32  downstream address
- mem_inst_wdata  out  32  constant 0
- mem_inst_rdata  in  32  downstream read data
- mem_inst_addr_ok  in  1  downstream accepted the request
- mem_inst_data_ok  in  1  downstream data valid

Behaviour:
- Address fields:
  - offset = addr[1:0]
  - index = addr[INDEX_W+1:2]
  - tag = addr[31:INDEX_W+2]
  - uncached = (addr[31:29] == UNCACHED_SEG)
- Storage:
  - valid[] is held in flops and cleared by reset.
  - tag[] and data[] have no reset.
- FSM states: IDLE, LOOKUP, MISS, REFILL. Reset state is IDLE.
- IDLE:
  - cpu_inst_addr_ok = cpu_inst_req && !cache_inv. This path is combinational.
  - On accept, latch addr, size and uncached into the request registers, then go to LOOKUP.
  - If cache_inv is high, clear all valid bits this cycle; no request is accepted.
- LOOKUP:
  - hit = !uncached && valid[idx] && tag[idx] == req_tag.
  - On hit: cpu_inst_data_ok = 1 and cpu_inst_rdata = data[idx]; go to IDLE.
  - On miss or uncached: go to MISS.
  - Hit latency is 1 cycle after accept. The earliest next accept is 2 cycles after the previous accept.
- MISS:
  - mem_inst_req = 1.
  - Cached access: mem_inst_addr = {req_addr[31:2], 2'b00} and mem_inst_size = 2'b10.
  - Uncached access: mem_inst_addr = req_addr and mem_inst_size = req_size.
  - When mem_inst_addr_ok = 1, go to REFILL.
  - mem_inst_req, addr and size stay stable until mem_inst_addr_ok.
- REFILL:
  - mem_inst_req = 0.
  - On mem_inst_data_ok:
    - cpu_inst_data_ok = 1 and cpu_inst_rdata = mem_inst_rdata, in the same cycle (combinational pass-through).
    - If cacheable: write data[idx] = mem_inst_rdata and tag[idx] = req_tag, and set valid[idx].
    - Go to IDLE.
- cpu_inst_addr_ok is 0 in every state except IDLE.
- cache_inv outside IDLE:
  - The pulse is recorded in a pending flag and applied on the next entry to IDLE.
  - The pending clear takes effect before the in-flight refill's valid write: the refilled line ends up invalid.
- Outputs at reset: cpu_inst_addr_ok=0, cpu_inst_data_ok=0, cpu_inst_rdata=0, mem_inst_req=0, mem_inst_size=0, mem_inst_addr=0.
- cpu_inst_rdata holds its last value when data_ok=0, using a registered copy.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and all valid bits clear.
  - The outstanding downstream transaction is abandoned. The bridge shares the same reset, so it is discarded there too.
- Sub-word fetches return the full aligned word; the CPU selects bytes using offset.

Decomposition:
- Shared package cache_pkg holds:
  - the state enum icache_state_t {IDLE, LOOKUP, MISS, REFILL}
  - the UNCACHED_SEG default
  - the SIZE_WORD = 2'b10 constant
  - a function addr_uncached()
- One sub-module, icache_line_store:
  - tag, data and valid arrays
  - one combinational read port indexed by idx
  - one write port
  - a single-cycle invalidate-all input
  - the async reset on valid

Test Plan:
- Cold miss then hit: fetch 0x8000_0010. Expect mem_inst_req with addr 0x8000_0010, size 2. Memory returns 0x2402_0001. Expect data_ok with that value, then refetch returns data_ok exactly 1 cycle after addr_ok with 0x2402_0001 and no mem_inst_req.
- Conflict eviction (INDEX_W=8): fill 0x8000_0010, then fetch 0x8000_0410 (same index, new tag). Expect a miss; a refetch of 0x8000_0010 misses again.
- Uncached bypass: fetch 0xBFC0_0002 with size 1. Expect mem_inst_addr 0xBFC0_0002, size 1. Refetching the same address misses again and no array write occurs.
- Downstream backpressure: hold mem_inst_addr_ok=0 for 5 cycles. mem_inst_req and addr stay stable and cpu_inst_addr_ok stays 0; data_ok arrives 3 cycles after addr_ok and is forwarded the same cycle.
- Invalidate:
  - cache_inv in IDLE after filling 0x8000_0010 → the next fetch of that address misses.
  - cache_inv pulsed during REFILL → the refilled line reads as invalid afterwards.
- Async reset: assert resetn=0 in REFILL → outputs are 0 immediately. After release, a fetch of a previously cached address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   icache_state_t   : controller states
//   UNCACHED_SEG_DFLT: addr[31:29] value of the uncached segment (kseg1)
//   SIZE_WORD        : sram-like size code for a full 32-bit word
//   addr_uncached()  : compares an address segment against the uncached segment
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    REFILL = 2'd3
  } icache_state_t;

  localparam logic [2:0] UNCACHED_SEG_DFLT = 3'b101;
  localparam logic [1:0] SIZE_WORD         = 2'b10;

  function automatic logic addr_uncached(input logic [2:0] seg, input logic [2:0] unc_seg);
    return seg == unc_seg;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag/data/valid storage for the direct-mapped instruction cache.
// Ports:
//   i_clk, i_resetn : clock, async active-low reset (clears valid bits only)
//   i_idx           : line index shared by the read port and the write port
//   o_valid/o_tag/o_data : combinational read of line i_idx
//   i_we, i_wtag, i_wdata: write tag/data of line i_idx and set its valid bit
//   i_inv_all       : clear every valid bit this cycle; wins over i_we
module icache_line_store #(
  parameter int INDEX_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [INDEX_W-1:0]   i_idx,
  output logic                 o_valid,
  output logic [29-INDEX_W:0]  o_tag,
  output logic [31:0]          o_data,
  input  logic                 i_we,
  input  logic [29-INDEX_W:0]  i_wtag,
  input  logic [31:0]          i_wdata,
  input  logic                 i_inv_all
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  // An invalidate landing together with a refill leaves the refilled line invalid.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_valid <= '0;
    end else if (i_inv_all) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_idx]  <= i_wtag;
      r_data[i_idx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with one-word lines, between the
// CPU fetch stage and the sram-like instruction port of the AXI bridge.
// Ports:
//   clk, resetn            : clock, async active-low reset
//   cpu_inst_*             : sram-like fetch interface from the CPU
//   cache_inv              : pulse, invalidate all lines
//   mem_inst_*             : sram-like read interface to the bridge (never writes)
//
// state  | meaning
// IDLE   | waiting for a fetch; accepts it combinationally
// LOOKUP | compare latched request against the indexed line
// MISS   | downstream request held until mem_inst_addr_ok
// REFILL | waiting for mem_inst_data_ok; forward data, fill line if cacheable
module icache_dm
  import cache_pkg::*;
#(
  parameter int         INDEX_W      = 8,
  parameter logic [2:0] UNCACHED_SEG = UNCACHED_SEG_DFLT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_inst_req,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic [31:0] cpu_inst_rdata,
  input  logic        cache_inv,
  output logic        mem_inst_req,
  output logic        mem_inst_wr,
  output logic [1:0]  mem_inst_size,
  output logic [31:0] mem_inst_addr,
  output logic [31:0] mem_inst_wdata,
  input  logic [31:0] mem_inst_rdata,
  input  logic        mem_inst_addr_ok,
  input  logic        mem_inst_data_ok
);

  localparam int TAG_W = 30 - INDEX_W;

  icache_state_t r_state;
  logic [31:0]   r_req_addr;
  logic [1:0]    r_req_size;
  logic          r_req_unc;
  logic          r_inv_pend;
  logic [31:0]   r_rdata;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_req_tag;
  logic               w_ln_valid;
  logic [TAG_W-1:0]   w_ln_tag;
  logic [31:0]        w_ln_data;
  logic               w_hit;
  logic               w_refill_done;
  logic               w_to_idle;
  logic               w_inv_all;
  logic               w_we;

  assign w_idx     = r_req_addr[INDEX_W+1:2];
  assign w_req_tag = r_req_addr[31:INDEX_W+2];

  assign w_hit         = (r_state == LOOKUP) && !r_req_unc && w_ln_valid && (w_ln_tag == w_req_tag);
  assign w_refill_done = (r_state == REFILL) && mem_inst_data_ok;
  assign w_to_idle     = w_hit || w_refill_done;

  // Invalidate directly in IDLE, or on the way back to IDLE if one arrived while
  // busy. The line store gives the clear priority over the refill's valid set.
  assign w_inv_all = ((r_state == IDLE) && cache_inv) || (w_to_idle && (r_inv_pend || cache_inv));
  assign w_we      = w_refill_done && !r_req_unc;

  icache_line_store #(
    .INDEX_W (INDEX_W)
  ) u_line_store (
    .i_clk     (clk),
    .i_resetn  (resetn),
    .i_idx     (w_idx),
    .o_valid   (w_ln_valid),
    .o_tag     (w_ln_tag),
    .o_data    (w_ln_data),
    .i_we      (w_we),
    .i_wtag    (w_req_tag),
    .i_wdata   (mem_inst_rdata),
    .i_inv_all (w_inv_all)
  );

  // Gated with resetn so the accept strobe is low for the whole reset window.
  assign cpu_inst_addr_ok = resetn && (r_state == IDLE) && cpu_inst_req && !cache_inv;
  assign cpu_inst_data_ok = w_to_idle;
  assign cpu_inst_rdata   = w_hit ? w_ln_data : (w_refill_done ? mem_inst_rdata : r_rdata);

  assign mem_inst_req   = (r_state == MISS);
  assign mem_inst_wr    = 1'b0;
  assign mem_inst_wdata = '0;
  assign mem_inst_addr  = (r_state != MISS) ? '0 :
                          (r_req_unc ? r_req_addr : {r_req_addr[31:2], 2'b00});
  assign mem_inst_size  = (r_state != MISS) ? '0 :
                          (r_req_unc ? r_req_size : SIZE_WORD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_req_addr <= '0;
      r_req_size <= '0;
      r_req_unc  <= 1'b0;
      r_inv_pend <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (cpu_inst_data_ok) begin
        r_rdata <= cpu_inst_rdata;
      end

      if (w_to_idle) begin
        r_inv_pend <= 1'b0;
      end else if ((r_state != IDLE) && cache_inv) begin
        r_inv_pend <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (cpu_inst_addr_ok) begin
            r_req_addr <= cpu_inst_addr;
            r_req_size <= cpu_inst_size;
            r_req_unc  <= addr_uncached(cpu_inst_addr[31:29], UNCACHED_SEG);
            r_state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_state <= w_hit ? IDLE : MISS;
        end
        MISS: begin
          if (mem_inst_addr_ok) begin
            r_state <= REFILL;
          end
        end
        REFILL: begin
          if (mem_inst_data_ok) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_inst_req;
  logic [1:0]  cpu_inst_size;
  logic [31:0] cpu_inst_addr;
  logic        cpu_inst_addr_ok;
  logic        cpu_inst_data_ok;
  logic [31:0] cpu_inst_rdata;
  logic        cache_inv;
  logic        mem_inst_req;
  logic        mem_inst_wr;
  logic [1:0]  mem_inst_size;
  logic [31:0] mem_inst_addr;
  logic [31:0] mem_inst_wdata;
  logic [31:0] mem_inst_rdata;
  logic        mem_inst_addr_ok;
  logic        mem_inst_data_ok;

  icache_dm #(
    .INDEX_W      (8),
    .UNCACHED_SEG (3'b101)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .cpu_inst_req     (cpu_inst_req),
    .cpu_inst_size    (cpu_inst_size),
    .cpu_inst_addr    (cpu_inst_addr),
    .cpu_inst_addr_ok (cpu_inst_addr_ok),
    .cpu_inst_data_ok (cpu_inst_data_ok),
    .cpu_inst_rdata   (cpu_inst_rdata),
    .cache_inv        (cache_inv),
    .mem_inst_req     (mem_inst_req),
    .mem_inst_wr      (mem_inst_wr),
    .mem_inst_size    (mem_inst_size),
    .mem_inst_addr    (mem_inst_addr),
    .mem_inst_wdata   (mem_inst_wdata),
    .mem_inst_rdata   (mem_inst_rdata),
    .mem_inst_addr_ok (mem_inst_addr_ok),
    .mem_inst_data_ok (mem_inst_data_ok)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0010) return 32'h2402_0001;
    return a ^ 32'h1357_9BDF;
  endfunction

  // One fetch, called at posedge+1. Inputs change at posedge+1 (mem_inst_addr_ok
  // also at negedge, it has no combinational path); outputs sampled at negedge.
  task automatic fetch(input string name, input logic [31:0] addr, input logic [1:0] size,
                       input bit exp_miss, input int aok_dly, input int dok_dly,
                       input bit inv_in_refill, input bit rst_in_refill);
    logic        unc       = (addr[31:29] == 3'b101);
    logic [31:0] exp_maddr = unc ? addr : {addr[31:2], 2'b00};
    logic [1:0]  exp_msize = unc ? size : 2'b10;
    logic [31:0] exp_d;
    bit accepted = 0, done = 0, seen = 0, busy_aok = 0, unstable = 0, late_req = 0;
    int phase = 1, req_cnt = 0, dcnt = 0, acc_cyc = 0, hs_cyc = 0, data_cyc = 0;
    cpu_inst_req  = 1'b1;
    cpu_inst_addr = addr;
    cpu_inst_size = size;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        mem_inst_addr_ok = 1'b0;
        mem_inst_data_ok = 1'b0;
        cache_inv        = 1'b0;
        if (phase == 2) begin
          if (rst_in_refill) begin
            resetn = 1'b0;
            #1;
            chk({name, "/rst_addr_ok"}, cpu_inst_addr_ok, 0);
            chk({name, "/rst_data_ok"}, cpu_inst_data_ok, 0);
            chk({name, "/rst_rdata"},   cpu_inst_rdata, 0);
            chk({name, "/rst_mem_req"}, mem_inst_req, 0);
            chk({name, "/rst_mem_addr"}, mem_inst_addr, 0);
            chk({name, "/rst_mem_size"}, mem_inst_size, 0);
            exp_d = sb_q.pop_back();
            last_rdata = '0;
            done = 1;
            continue;
          end
          if (inv_in_refill && dcnt == 1) cache_inv = 1'b1;
          if (dcnt == dok_dly) begin
            mem_inst_data_ok = 1'b1;
            mem_inst_rdata   = mem_word(exp_maddr);
            phase = 3;
          end else begin
            dcnt++;
          end
        end
      end
      @(negedge clk);
      if (cyc == 0) chk({name, "/rdata_hold"}, cpu_inst_rdata, last_rdata);
      if (!accepted) begin
        if (cpu_inst_addr_ok) begin
          accepted = 1;
          acc_cyc  = cyc;
          sb_q.push_back(mem_word(exp_maddr));
        end
      end else if (cpu_inst_addr_ok) begin
        busy_aok = 1;
      end
      if (mem_inst_req) begin
        if (phase != 1 || !accepted) begin
          late_req = 1;
        end else begin
          if (!seen) begin
            seen = 1;
            chk({name, "/mem_addr"}, mem_inst_addr, exp_maddr);
            chk({name, "/mem_size"}, mem_inst_size, exp_msize);
          end else if (mem_inst_addr !== exp_maddr || mem_inst_size !== exp_msize) begin
            unstable = 1;
          end
          if (req_cnt == aok_dly) begin
            mem_inst_addr_ok = 1'b1;
            phase  = 2;
            dcnt   = 1;
            hs_cyc = cyc;
          end
          req_cnt++;
        end
      end
      if (cpu_inst_data_ok) begin
        if (sb_q.size() == 0) begin
          chk({name, "/sb_nonempty"}, sb_q.size(), 1);
        end else begin
          exp_d = sb_q.pop_front();
          chk({name, "/rdata"}, cpu_inst_rdata, exp_d);
          last_rdata = exp_d;
        end
        done = 1;
        data_cyc = cyc;
      end
    end
    chk({name, "/done"}, done, 1);
    if (!rst_in_refill) begin
      chk({name, "/miss"}, seen, exp_miss);
      if (!exp_miss) chk({name, "/hit_lat"}, data_cyc - acc_cyc, 1);
      else           chk({name, "/data_lat"}, data_cyc - hs_cyc, dok_dly);
      chk({name, "/busy_addr_ok"}, busy_aok, 0);
      chk({name, "/mem_stable"}, unstable, 0);
      chk({name, "/late_mem_req"}, late_req, 0);
    end
    @(posedge clk); #1;
    cpu_inst_req     = 1'b0;
    mem_inst_addr_ok = 1'b0;
    mem_inst_data_ok = 1'b0;
    cache_inv        = 1'b0;
    resetn           = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn           = 1'b0;
    cpu_inst_req     = 1'b1;
    cpu_inst_size    = 2'b10;
    cpu_inst_addr    = 32'h8000_0010;
    cache_inv        = 1'b0;
    mem_inst_rdata   = '0;
    mem_inst_addr_ok = 1'b0;
    mem_inst_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/addr_ok",  cpu_inst_addr_ok, 0);
    chk("reset/data_ok",  cpu_inst_data_ok, 0);
    chk("reset/rdata",    cpu_inst_rdata, 0);
    chk("reset/mem_req",  mem_inst_req, 0);
    chk("reset/mem_size", mem_inst_size, 0);
    chk("reset/mem_addr", mem_inst_addr, 0);
    chk("reset/mem_wr",   mem_inst_wr, 0);
    chk("reset/mem_wdata", mem_inst_wdata, 0);
    cpu_inst_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // cold miss, hit, sub-word hit
    fetch("cold",     32'h8000_0010, 2'd2, 1, 0, 1, 0, 0);
    fetch("hit",      32'h8000_0010, 2'd2, 0, 0, 1, 0, 0);
    fetch("hit_half", 32'h8000_0012, 2'd1, 0, 0, 1, 0, 0);
    // conflict eviction on index 4
    fetch("conflict", 32'h8000_0410, 2'd2, 1, 0, 2, 0, 0);
    fetch("evicted",  32'h8000_0010, 2'd2, 1, 1, 1, 0, 0);
    fetch("rehit",    32'h8000_0010, 2'd2, 0, 0, 1, 0, 0);
    // uncached bypass
    fetch("unc1",     32'hBFC0_0002, 2'd1, 1, 0, 1, 0, 0);
    fetch("unc2",     32'hBFC0_0002, 2'd1, 1, 0, 1, 0, 0);
    // downstream backpressure
    fetch("bp",       32'h8000_0100, 2'd2, 1, 5, 3, 0, 0);
    fetch("bp_hit",   32'h8000_0100, 2'd2, 0, 0, 1, 0, 0);

    // invalidate in IDLE, with a request present that must not be taken
    cpu_inst_req  = 1'b1;
    cpu_inst_addr = 32'h8000_0010;
    cpu_inst_size = 2'd2;
    cache_inv     = 1'b1;
    @(negedge clk);
    chk("inv_idle/addr_ok", cpu_inst_addr_ok, 0);
    @(posedge clk); #1;
    cpu_inst_req = 1'b0;
    cache_inv    = 1'b0;
    fetch("inv_a",    32'h8000_0010, 2'd2, 1, 0, 1, 0, 0);
    fetch("inv_b",    32'h8000_0100, 2'd2, 1, 0, 1, 0, 0);

    // invalidate while refilling
    fetch("inv_rf",   32'h8000_0200, 2'd2, 1, 1, 3, 1, 0);
    fetch("inv_rf2",  32'h8000_0200, 2'd2, 1, 0, 1, 0, 0);
    fetch("inv_rf3",  32'h8000_0010, 2'd2, 1, 0, 1, 0, 0);
    fetch("pre_rst",  32'h8000_0010, 2'd2, 0, 0, 1, 0, 0);

    // reset in REFILL
    fetch("rst_rf",   32'h8000_0300, 2'd2, 1, 0, 3, 0, 1);
    fetch("post_rst", 32'h8000_0010, 2'd2, 1, 0, 1, 0, 0);
    fetch("post_hit", 32'h8000_0010, 2'd2, 0, 0, 1, 0, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
